// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: sequences divider load/enable and steps the waveform ROM address
// in sawtooth or triangle sweeps, continuously or for exactly one period.
module wave_seq_ctrl #(
    parameter int DIV_W  = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              start,
    input  logic              mode,
    input  logic              sel,
    input  logic [DIV_W-1:0]  SW,
    input  logic              div_co,
    output logic [DIV_W-1:0]  div_val,
    output logic              load_div,
    output logic              div_en,
    output logic              sample_en,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, INIT, ARM, RUN, DONE} state_t;
    localparam logic [ADDR_W-1:0] AMAX = '1;
    state_t state_q, state_d;
    logic dir_q, dir_d;
    logic cfg_mode_q, cfg_mode_d, cfg_sel_q, cfg_sel_d;
    logic [DIV_W-1:0] div_val_q, div_val_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic load_div_q, div_en_q, sample_en_q, sample_en_d, busy_q, done_q, last;
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cfg_mode_d  = cfg_mode_q;
        cfg_sel_d   = cfg_sel_q;
        div_val_d   = div_val_q;
        addr_d      = addr_q;
        sample_en_d = 1'b0;
        last        = 1'b0;
        case (state_q)
            IDLE: begin
                if (init) begin
                    state_d   = INIT;
                    div_val_d = (SW == '0) ? DIV_W'(1) : SW;
                    addr_d    = '0;
                    dir_d     = 1'b0;
                end else if (start) begin
                    state_d    = ARM;
                    cfg_mode_d = mode;
                    cfg_sel_d  = sel;
                end
            end
            INIT: state_d = IDLE;
            ARM:  state_d = RUN;
            RUN: begin
                sample_en_d = div_co;
                if (div_co) begin
                    // dir_q=1 means the triangle is sweeping down
                    if (!cfg_mode_q) begin
                        addr_d = addr_q + 1'b1;
                    end else if (!dir_q) begin
                        addr_d = (addr_q == AMAX) ? AMAX - 1'b1 : addr_q + 1'b1;
                        dir_d  = (addr_q == AMAX);
                    end else begin
                        addr_d = (addr_q == '0) ? ADDR_W'(1) : addr_q - 1'b1;
                        dir_d  = (addr_q != '0);
                    end
                    last = cfg_sel_q && (cfg_mode_q ? (dir_q && addr_q == ADDR_W'(1)) : (addr_q == AMAX));
                end
                if (last) dir_d = 1'b0;
                if (last || (start && !cfg_sel_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            cfg_mode_q  <= 1'b0;
            cfg_sel_q   <= 1'b0;
            div_val_q   <= '0;
            addr_q      <= '0;
            load_div_q  <= 1'b0;
            div_en_q    <= 1'b0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_sel_q   <= cfg_sel_d;
            div_val_q   <= div_val_d;
            addr_q      <= addr_d;
            load_div_q  <= (state_d == ARM);
            div_en_q    <= (state_d == RUN);
            sample_en_q <= sample_en_d;
            busy_q      <= (state_d == ARM) || (state_d == RUN);
            done_q      <= (state_d == DONE);
        end
    end
    assign div_val   = div_val_q;
    assign load_div  = load_div_q;
    assign div_en    = div_en_q;
    assign sample_en = sample_en_q;
    assign addr      = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl: scoreboard bench; expected addresses are queued as div_co is driven
// and compared against each sample_en strobe.
module tb_wave_seq_ctrl;
    logic clk = 1'b0, rst = 1'b0, init = 1'b0, start = 1'b0, mode = 1'b0, sel = 1'b0, div_co = 1'b0;
    logic [9:0] SW = '0, div_val;
    logic [7:0] addr;
    logic load_div, div_en, sample_en, busy, done;
    int n_chk = 0, n_fail = 0, n_samp = 0, n_done = 0;
    int sb[$];
    int m_addr = 0;
    bit m_dir = 0, m_mode = 0;
    int b_samp, b_done;

    wave_seq_ctrl dut (
        .clk(clk), .rst(rst), .init(init), .start(start), .mode(mode), .sel(sel), .SW(SW),
        .div_co(div_co), .div_val(div_val), .load_div(load_div), .div_en(div_en),
        .sample_en(sample_en), .addr(addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference address model, advanced once per driven div_co in RUN
    task automatic model_step();
        if (!m_mode) m_addr = (m_addr + 1) % 256;
        else if (!m_dir) begin
            if (m_addr == 255) begin m_dir = 1; m_addr = 254; end
            else m_addr++;
        end else begin
            if (m_addr == 0) begin m_dir = 0; m_addr = 1; end
            else m_addr--;
        end
        sb.push_back(m_addr);
    endtask

    task automatic pulse();
        div_co = 1'b1;
        model_step();
        tick();
        div_co = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_run(input bit m, input bit s);
        mode = m;
        sel = s;
        m_mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_load_div", load_div, 1);
        chk("arm_div_en", div_en, 0);
        chk("arm_busy", busy, 1);
        tick();
        chk("run_load_div", load_div, 0);
        chk("run_div_en", div_en, 1);
        chk("run_busy", busy, 1);
    endtask

    always @(negedge clk) begin
        if (sample_en) begin
            n_samp++;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sample_addr", addr, sb.pop_front());
        end
        if (done) begin
            n_done++;
            chk("busy_at_done", busy, 0);
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_div_val", div_val, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_en", div_en, 0);
        rst = 1'b1;
        SW = 10'b1001101101;
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_div_val", div_val, 'h26D);
        chk("init_addr", addr, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        init = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        init = 1'b0;
        chk("rst_mid_init_div_val", div_val, 0);
        chk("rst_mid_init_addr", addr, 0);
        tick();
        SW = '0;
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("sw0_div_val", div_val, 1);
        tick();
        m_addr = 0; m_dir = 0;

        // sawtooth single period
        b_samp = n_samp; b_done = n_done;
        start_run(0, 1);
        repeat (255) pulse();
        chk("saw_no_early_done", n_done - b_done, 0);
        pulse();
        chk("saw_samples", n_samp - b_samp, 256);
        chk("saw_done_once", n_done - b_done, 1);
        chk("saw_addr_end", addr, 0);
        chk("saw_busy_end", busy, 0);
        chk("saw_div_en_end", div_en, 0);
        chk("saw_sb_empty", sb.size(), 0);

        // triangle single period, mode toggled mid-run
        b_samp = n_samp; b_done = n_done;
        start_run(1, 1);
        repeat (100) pulse();
        mode = 1'b0;
        repeat (409) pulse();
        chk("tri_no_early_done", n_done - b_done, 0);
        pulse();
        m_dir = 0;
        chk("tri_samples", n_samp - b_samp, 510);
        chk("tri_done_once", n_done - b_done, 1);
        chk("tri_addr_end", addr, 0);
        chk("tri_busy_end", busy, 0);
        chk("tri_sb_empty", sb.size(), 0);

        // continuous run, stopped by start coincident with div_co
        b_samp = n_samp; b_done = n_done;
        start_run(0, 0);
        repeat (300) pulse();
        chk("cont_no_done", n_done - b_done, 0);
        chk("cont_busy", busy, 1);
        start = 1'b1;
        div_co = 1'b1;
        model_step();
        tick();
        start = 1'b0;
        div_co = 1'b0;
        chk("cont_stop_done", done, 1);
        chk("cont_stop_addr", addr, m_addr);
        repeat (3) tick();
        chk("cont_hold_addr", addr, m_addr);
        chk("cont_samples", n_samp - b_samp, 301);
        chk("cont_done_once", n_done - b_done, 1);
        chk("cont_busy_end", busy, 0);

        // init and start together: init wins
        SW = 10'd5;
        init = 1'b1;
        start = 1'b1;
        tick();
        init = 1'b0;
        start = 1'b0;
        m_addr = 0; m_dir = 0;
        chk("initstart_busy", busy, 0);
        chk("initstart_load_div", load_div, 0);
        chk("initstart_div_val", div_val, 5);
        chk("initstart_addr", addr, 0);
        tick();
        chk("initstart_busy2", busy, 0);
        chk("initstart_load_div2", load_div, 0);

        // div_co while idle is ignored
        div_co = 1'b1;
        tick();
        div_co = 1'b0;
        tick();
        chk("idle_divco_addr", addr, 0);

        // reset in the middle of a run
        b_done = n_done;
        start_run(0, 0);
        repeat (5) pulse();
        chk("prerst_addr", addr, 5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_addr = 0; m_dir = 0;
        chk("midrst_div_en", div_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_div_val", div_val, 0);
        chk("midrst_load_div", load_div, 0);
        chk("midrst_done", done, 0);
        repeat (3) tick();
        chk("midrst_no_done", n_done - b_done, 0);
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
